// File: rtl/tap_controller_if.sv
// TAP pin bundle: TMS/TDI in, state strobes, IR_TDO and instruction selects out.
// The master side drives the test pins; the slave side is the TAP controller.
interface tap_controller_if;
    logic TMS;
    logic TDI;
    logic Shift_DR;
    logic Capture_DR;
    logic Update_DR;
    logic DR_clk_en;
    logic Shift_IR;
    logic IR_TDO;
    logic Select_ID;
    logic Select_BYPASS;
    logic TLR;

    modport master (
        output TMS, TDI,
        input  Shift_DR, Capture_DR, Update_DR, DR_clk_en, Shift_IR,
               IR_TDO, Select_ID, Select_BYPASS, TLR
    );

    modport slave (
        input  TMS, TDI,
        output Shift_DR, Capture_DR, Update_DR, DR_clk_en, Shift_IR,
               IR_TDO, Select_ID, Select_BYPASS, TLR
    );
endinterface

// File: rtl/tap_controller.sv
// IEEE 1149.1 TAP controller with IR and IDCODE/BYPASS decode.
// Optional macro TAP_STATE_DEBUG_EN exposes the raw state register on tap_state.
module tap_controller #(
    parameter int              IR_W      = 4,
    parameter logic [IR_W-1:0] IDCODE_OP = IR_W'(4'b0010),
    parameter logic [IR_W-1:0] BYPASS_OP = IR_W'(4'b1111)
) (
    input  logic             clk,
    input  logic             rst,
    tap_controller_if.slave  tap
`ifdef TAP_STATE_DEBUG_EN
    ,
    output logic [3:0]       tap_state
`endif
);
    localparam logic [3:0] ST_TLR     = 4'hF;
    localparam logic [3:0] ST_RTI     = 4'hC;
    localparam logic [3:0] ST_SELDR   = 4'h7;
    localparam logic [3:0] ST_CAPDR   = 4'h6;
    localparam logic [3:0] ST_SHDR    = 4'h2;
    localparam logic [3:0] ST_EX1DR   = 4'h1;
    localparam logic [3:0] ST_PAUSEDR = 4'h3;
    localparam logic [3:0] ST_EX2DR   = 4'h0;
    localparam logic [3:0] ST_UPDDR   = 4'h5;
    localparam logic [3:0] ST_SELIR   = 4'h4;
    localparam logic [3:0] ST_CAPIR   = 4'hE;
    localparam logic [3:0] ST_SHIR    = 4'hA;
    localparam logic [3:0] ST_EX1IR   = 4'h9;
    localparam logic [3:0] ST_PAUSEIR = 4'hB;
    localparam logic [3:0] ST_EX2IR   = 4'h8;
    localparam logic [3:0] ST_UPDIR   = 4'hD;

    logic [3:0]      state_r;
    logic [3:0]      next_state_s;
    logic [IR_W-1:0] ir_shift_r;
    logic [IR_W-1:0] ir_active_r;
    logic            capture_dr_s;
    logic            shift_dr_s;

    // Next-state logic of the 16-state TAP FSM.
    always_comb begin
        next_state_s = ST_TLR;
        case (state_r)
            ST_TLR:     next_state_s = tap.TMS ? ST_TLR     : ST_RTI;
            ST_RTI:     next_state_s = tap.TMS ? ST_SELDR   : ST_RTI;
            ST_SELDR:   next_state_s = tap.TMS ? ST_SELIR   : ST_CAPDR;
            ST_CAPDR:   next_state_s = tap.TMS ? ST_EX1DR   : ST_SHDR;
            ST_SHDR:    next_state_s = tap.TMS ? ST_EX1DR   : ST_SHDR;
            ST_EX1DR:   next_state_s = tap.TMS ? ST_UPDDR   : ST_PAUSEDR;
            ST_PAUSEDR: next_state_s = tap.TMS ? ST_EX2DR   : ST_PAUSEDR;
            ST_EX2DR:   next_state_s = tap.TMS ? ST_UPDDR   : ST_SHDR;
            ST_UPDDR:   next_state_s = tap.TMS ? ST_SELDR   : ST_RTI;
            ST_SELIR:   next_state_s = tap.TMS ? ST_TLR     : ST_CAPIR;
            ST_CAPIR:   next_state_s = tap.TMS ? ST_EX1IR   : ST_SHIR;
            ST_SHIR:    next_state_s = tap.TMS ? ST_EX1IR   : ST_SHIR;
            ST_EX1IR:   next_state_s = tap.TMS ? ST_UPDIR   : ST_PAUSEIR;
            ST_PAUSEIR: next_state_s = tap.TMS ? ST_EX2IR   : ST_PAUSEIR;
            ST_EX2IR:   next_state_s = tap.TMS ? ST_UPDIR   : ST_SHIR;
            ST_UPDIR:   next_state_s = tap.TMS ? ST_SELDR   : ST_RTI;
            default:    next_state_s = ST_TLR;
        endcase
    end

    // State, IR shift register and active instruction register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_TLR;
            ir_shift_r  <= {IR_W{1'b0}};
            ir_active_r <= IDCODE_OP;
        end else begin
            state_r <= next_state_s;
            case (state_r)
                ST_CAPIR: ir_shift_r <= IR_W'(2'b01);
                ST_SHIR:  ir_shift_r <= {tap.TDI, ir_shift_r[IR_W-1:1]};
                default:  ir_shift_r <= ir_shift_r;
            endcase
            // TLR keeps forcing IDCODE so the chip always wakes with ID selected.
            if (state_r == ST_TLR) begin
                ir_active_r <= IDCODE_OP;
            end else if (state_r == ST_UPDIR) begin
                ir_active_r <= ir_shift_r;
            end else begin
                ir_active_r <= ir_active_r;
            end
        end
    end

    assign capture_dr_s = (state_r == ST_CAPDR);
    assign shift_dr_s   = (state_r == ST_SHDR);

    assign tap.Capture_DR    = capture_dr_s;
    assign tap.Shift_DR      = shift_dr_s;
    assign tap.Update_DR     = (state_r == ST_UPDDR);
    assign tap.DR_clk_en     = capture_dr_s | shift_dr_s;
    assign tap.Shift_IR      = (state_r == ST_SHIR);
    assign tap.TLR           = (state_r == ST_TLR);
    assign tap.IR_TDO        = ir_shift_r[0];
    // Anything other than IDCODE (defined BYPASS or undefined opcodes) selects bypass.
    assign tap.Select_ID     = (ir_active_r == IDCODE_OP);
    assign tap.Select_BYPASS = (ir_active_r == BYPASS_OP) || (ir_active_r != IDCODE_OP);

`ifdef TAP_STATE_DEBUG_EN
    assign tap_state = state_r;
`endif
endmodule

// File: tb/tb_tap_controller.sv
// Self-checking bench for tap_controller: directed TAP sequences plus random TMS/TDI
// walks with random asynchronous resets, compared against a named-state reference model.
module tb_tap_controller;
    localparam int         IR_W      = 4;
    localparam logic [3:0] IDCODE_OP = 4'b0010;
    localparam logic [3:0] BYPASS_OP = 4'b1111;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tap_controller_if bus ();
`ifdef TAP_STATE_DEBUG_EN
    logic [3:0] tap_state;
`endif

    tap_controller #(.IR_W(IR_W), .IDCODE_OP(IDCODE_OP), .BYPASS_OP(BYPASS_OP)) dut (
        .clk (clk),
        .rst (rst),
        .tap (bus)
`ifdef TAP_STATE_DEBUG_EN
        ,
        .tap_state (tap_state)
`endif
    );

    typedef enum {M_TLR, M_RTI, M_SELDR, M_CAPDR, M_SHDR, M_EX1DR, M_PAUSEDR, M_EX2DR, M_UPDDR,
                  M_SELIR, M_CAPIR, M_SHIR, M_EX1IR, M_PAUSEIR, M_EX2IR, M_UPDIR} mstate_t;

    mstate_t m_st;
    int      m_sr;
    int      m_air;
    int      errors = 0;
    int      checks = 0;

    function automatic mstate_t m_next(mstate_t s, bit tms);
        case (s)
            M_TLR:     return tms ? M_TLR     : M_RTI;
            M_RTI:     return tms ? M_SELDR   : M_RTI;
            M_SELDR:   return tms ? M_SELIR   : M_CAPDR;
            M_SELIR:   return tms ? M_TLR     : M_CAPIR;
            M_CAPDR:   return tms ? M_EX1DR   : M_SHDR;
            M_SHDR:    return tms ? M_EX1DR   : M_SHDR;
            M_EX1DR:   return tms ? M_UPDDR   : M_PAUSEDR;
            M_PAUSEDR: return tms ? M_EX2DR   : M_PAUSEDR;
            M_EX2DR:   return tms ? M_UPDDR   : M_SHDR;
            M_UPDDR:   return tms ? M_SELDR   : M_RTI;
            M_CAPIR:   return tms ? M_EX1IR   : M_SHIR;
            M_SHIR:    return tms ? M_EX1IR   : M_SHIR;
            M_EX1IR:   return tms ? M_UPDIR   : M_PAUSEIR;
            M_PAUSEIR: return tms ? M_EX2IR   : M_PAUSEIR;
            M_EX2IR:   return tms ? M_UPDIR   : M_SHIR;
            M_UPDIR:   return tms ? M_SELDR   : M_RTI;
            default:   return M_TLR;
        endcase
    endfunction

`ifdef TAP_STATE_DEBUG_EN
    function automatic logic [3:0] m_enc(mstate_t s);
        case (s)
            M_TLR:     return 4'hF;  M_RTI:     return 4'hC;
            M_SELDR:   return 4'h7;  M_CAPDR:   return 4'h6;
            M_SHDR:    return 4'h2;  M_EX1DR:   return 4'h1;
            M_PAUSEDR: return 4'h3;  M_EX2DR:   return 4'h0;
            M_UPDDR:   return 4'h5;  M_SELIR:   return 4'h4;
            M_CAPIR:   return 4'hE;  M_SHIR:    return 4'hA;
            M_EX1IR:   return 4'h9;  M_PAUSEIR: return 4'hB;
            M_EX2IR:   return 4'h8;  M_UPDIR:   return 4'hD;
            default:   return 4'hX;
        endcase
    endfunction
`endif

    // Expected outputs: {TLR, Shift_DR, Capture_DR, Update_DR, DR_clk_en, Shift_IR, IR_TDO, Select_ID, Select_BYPASS}
    function automatic logic [8:0] m_outs();
        logic sel_id;
        logic sel_byp;
        sel_id  = (m_air == int'(IDCODE_OP));
        sel_byp = (m_air == int'(BYPASS_OP)) || (m_air != int'(IDCODE_OP) && m_air != int'(BYPASS_OP));
        return {m_st == M_TLR, m_st == M_SHDR, m_st == M_CAPDR, m_st == M_UPDDR,
                (m_st == M_CAPDR) || (m_st == M_SHDR), m_st == M_SHIR,
                m_sr[0], sel_id, sel_byp};
    endfunction

    logic [8:0] dut_outs;
    assign dut_outs = {bus.TLR, bus.Shift_DR, bus.Capture_DR, bus.Update_DR, bus.DR_clk_en,
                       bus.Shift_IR, bus.IR_TDO, bus.Select_ID, bus.Select_BYPASS};

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        check_val("outs", 32'(dut_outs), 32'(m_outs()));
`ifdef TAP_STATE_DEBUG_EN
        check_val("tap_state", 32'(tap_state), 32'(m_enc(m_st)));
`endif
    endtask

    task automatic model_reset();
        m_st  = M_TLR;
        m_sr  = 0;
        m_air = int'(IDCODE_OP);
    endtask

    task automatic model_edge(input bit tms, input bit tdi);
        int nair;
        int nsr;
        nair = m_air;
        nsr  = m_sr;
        if (m_st == M_TLR)       nair = int'(IDCODE_OP);
        else if (m_st == M_UPDIR) nair = m_sr;
        if (m_st == M_CAPIR)     nsr = 1;
        else if (m_st == M_SHIR) nsr = (m_sr >> 1) | (int'(tdi) << (IR_W - 1));
        m_air = nair;
        m_sr  = nsr;
        m_st  = m_next(m_st, tms);
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input bit tms, input bit tdi);
        bus.TMS = tms;
        bus.TDI = tdi;
        @(posedge clk);
        model_edge(tms, tdi);
        #1;
        check_all();
        @(negedge clk);
    endtask

    // Asynchronous reset asserted between edges, held across one rising edge.
    task automatic pulse_reset();
        #1;
        rst     = 1'b1;
        bus.TMS = 1'($urandom);
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        bus.TMS = 1'b0;
        bus.TDI = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        pulse_reset();
        check_val("rst_tlr", 32'(bus.TLR), 32'd1);
        check_val("rst_sel_id", 32'(bus.Select_ID), 32'd1);
        check_val("rst_dr_clk_en", 32'(bus.DR_clk_en), 32'd0);

        // Five TMS=1 from RTI, ShDR and PauseIR.
        step(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
        check_val("tlr_from_rti", 32'(bus.TLR), 32'd1);
        step(1'b0, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
        check_val("tlr_from_shdr", 32'(bus.TLR), 32'd1);
        step(1'b0, 1'b0); step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0);
        step(1'b0, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
        check_val("tlr_from_pauseir", 32'(bus.TLR), 32'd1);

        // DR capture / shift strobes.
        step(1'b0, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0);
        check_val("capture_dr", 32'(bus.Capture_DR), 32'd1);
        check_val("dr_clk_en_cap", 32'(bus.DR_clk_en), 32'd1);
        step(1'b0, 1'b0);
        check_val("shift_dr", 32'(bus.Shift_DR), 32'd1);
        check_val("dr_clk_en_sh", 32'(bus.DR_clk_en), 32'd1);
        step(1'b1, 1'b0);
        check_val("shift_dr_fall", 32'(bus.Shift_DR), 32'd0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);

        // Shift 1111 into the IR and update to BYPASS.
        step(1'b0, 1'b0); step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
        check_val("ir_tdo_0", 32'(bus.IR_TDO), 32'd1);
        step(1'b0, 1'b1);
        check_val("ir_tdo_1", 32'(bus.IR_TDO), 32'd0);
        step(1'b0, 1'b1); step(1'b0, 1'b1); step(1'b1, 1'b1);
        check_val("sel_id_before_upd", 32'(bus.Select_ID), 32'd1);
        step(1'b1, 1'b0); step(1'b0, 1'b0);
        check_val("sel_bypass", 32'(bus.Select_BYPASS), 32'd1);
        check_val("sel_id_off", 32'(bus.Select_ID), 32'd0);

        // Reset during the second ShIR cycle.
        step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        pulse_reset();
        check_val("mid_rst_tlr", 32'(bus.TLR), 32'd1);
        check_val("mid_rst_sel_id", 32'(bus.Select_ID), 32'd1);

        // Random walk with occasional asynchronous resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) pulse_reset();
            else step(($urandom_range(0, 99) < 45), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/tap_controller.md
TAP_CONTROLLER -- requirements
Module: tap_controller

Interface
REQ-001 SHALL provide parameter IR_W, default 4, meaning instruction register width in bits (minimum 2).
REQ-002 SHALL provide parameter IDCODE_OP, default 4'b0010, meaning the instruction loaded at reset that selects the ID register.
REQ-003 SHALL provide parameter BYPASS_OP, default 4'b1111, meaning the bypass instruction.
REQ-004 SHALL have one clock and an asynchronous, active-high reset: ports clk and rst.
REQ-005 clk  input  1  test clock (TCK); all state changes on the rising edge.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 TMS  input  1  test mode select, sampled on the clk rising edge.
REQ-008 TDI  input  1  serial data in, shifted into the IR in Shift-IR.
REQ-009 Shift_DR  output  1  high while in Shift-DR; drives the Shift_DR input of the ID register cells.
REQ-010 Capture_DR  output  1  high while in Capture-DR.
REQ-011 Update_DR  output  1  high while in Update-DR.
REQ-012 DR_clk_en  output  1  equals Capture_DR OR Shift_DR; the enable for the gated ID_t_clk of the ID register chain.
REQ-013 Shift_IR  output  1  high while in Shift-IR.
REQ-014 IR_TDO  output  1  equals bit 0 of the IR shift register.
REQ-015 Select_ID  output  1  high when the active instruction equals IDCODE_OP.
REQ-016 Select_BYPASS  output  1  high when the active instruction equals BYPASS_OP or any undefined opcode.
REQ-017 TLR  output  1  high while in Test-Logic-Reset.

Function
REQ-018 SHALL implement the 16-state IEEE 1149.1 TAP FSM as a 4-bit state register with this encoding:
- TLR=F, RTI=C
- SelDR=7, CapDR=6, ShDR=2, Ex1DR=1, PauseDR=3, Ex2DR=0, UpdDR=5
- SelIR=4, CapIR=E, ShIR=A, Ex1IR=9, PauseIR=B, Ex2IR=8, UpdIR=D
REQ-019 SHALL follow these transitions on each clk rising edge, written as TMS=0 / TMS=1:
- TLR: RTI / TLR; RTI: RTI / SelDR
- SelDR: CapDR / SelIR; SelIR: CapIR / TLR
- Cap: Sh / Ex1; Sh: Sh / Ex1; Ex1: Pause / Upd
- Pause: Pause / Ex2; Ex2: Sh / Upd; Upd: RTI / SelDR
- The Cap/Sh/Ex1/Pause/Ex2/Upd rules apply identically to the DR and IR branches.
REQ-020 SHALL reach TLR after 5 consecutive TMS=1 edges, from any state.
REQ-021 SHALL decode all state outputs combinationally from the state register, with zero-cycle latency relative to the state.
REQ-022 SHALL load the IR shift register with {0..0,2'b01} on the edge that leaves CapIR.
REQ-023 SHALL do the following on each edge taken while in ShIR:
- shift the IR right, with TDI entering the MSB;
- present the old bit 0 on IR_TDO before the edge.
REQ-024 SHALL copy the IR shift register into the active IR on the edge that leaves UpdIR; Select_ID and Select_BYPASS change in the cycle after that edge.
REQ-025 SHALL leave the active IR unchanged in the Ex1IR, PauseIR and Ex2IR states.
REQ-026 SHALL load IDCODE_OP into the active IR on every edge taken while in TLR.
REQ-027 SHALL assert at most one of Shift_DR, Capture_DR, Update_DR and Shift_IR in any cycle.

Reset
REQ-028 SHALL, on rst=1, immediately and without waiting for clk, set:
- state=TLR, IR shift register=0, active IR=IDCODE_OP;
- TLR=1, Select_ID=1;
- every other output=0.
REQ-029 SHALL abort any shift in progress on rst=1 mid-operation, discarding the partial IR content with no update.
REQ-030 SHALL take its first transition on the first clk rising edge after rst is released.

Configuration
REQ-031 SHALL provide the macro TAP_STATE_DEBUG_EN.
- When defined: adds output port tap_state [3:0] carrying the raw state register encoding.
- When undefined: the port is absent and all other behaviour is identical.

Verification
REQ-032 Assert rst with TMS=x, then release -> state=F, TLR=1, Select_ID=1, DR_clk_en=0.
REQ-033 From RTI, drive TMS=1,1,1,1,1 -> TLR=1 after the 5th edge; also repeat with the start state forced to ShDR and to PauseIR.
REQ-034 From TLR, drive TMS=0,1,0,0 -> Capture_DR=1 after edge 3 and Shift_DR=1 after edge 4; DR_clk_en=1 in both cycles; Shift_DR falls after the TMS=1 edge.
REQ-035 Enter ShIR, shift TDI=1,1,1,1 (last bit with TMS=1), then TMS=1,0 -> IR_TDO sequence 1,0,x,x; Select_BYPASS=1 in the cycle after leaving UpdIR.
REQ-036 Pulse rst during the 2nd ShIR cycle -> state=F in the same cycle, active IR=IDCODE_OP, Select_ID=1.
REQ-037 Build with and without TAP_STATE_DEBUG_EN -> with the macro, tap_state matches the REQ-018 encoding for every state; without it, the port is absent and REQ-032 through REQ-036 still pass.
